// File: rtl/rf_wport_sched_pkg.sv
// Shared definitions for the regfile write-port scheduler.
// No logic; widths, reset/enable polarities and the starvation default.
// Backpressure: not applicable.
package rf_wport_sched_pkg;
    localparam int          RegAddrBus  = 5;
    localparam int          RegBus      = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam int          StarveLimit = 4;
endpackage

// File: rtl/rf_result_fifo.sv
// Synchronous FIFO buffering long-latency results as {addr, data} pairs.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes are ignored while full and pops are ignored while empty.
module rf_result_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    // Extra MSB separates full from empty when the index bits match.
    logic [PTR_W:0]    wr_ptr, rd_ptr;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_addr = addr_q[rd_ptr[PTR_W-1:0]];
    assign head_data = data_q[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            addr_q[wr_ptr[PTR_W-1:0]] <= push_addr;
            data_q[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end
endmodule

// File: rtl/rf_wport_sched.sv
// Arbitrates the single regfile write port between WB and buffered LU results; tracks LU-pending regs.
// Latency: WB writes same cycle; an LU result reaches the port at earliest one cycle after push.
// Backpressure: lu_ready drops when the FIFO is full; wb_stall holds WB once the FIFO head has starved.
module rf_wport_sched
    import rf_wport_sched_pkg::*;
#(
    parameter int ADDR_W       = RegAddrBus,
    parameter int DATA_W       = RegBus,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = StarveLimit
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              wb_stall,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    output logic              lu_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_waddr,
    input  logic [ADDR_W-1:0] chk_raddr1,
    input  logic [ADDR_W-1:0] chk_raddr2,
    input  logic [ADDR_W-1:0] chk_waddr,
    output logic              busy1,
    output logic              busy2,
    output logic              busy_w,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic              in_rst;
    logic              wb_req, head_v, starved, pop, lu_push;
    logic              fifo_full, fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  starve_cnt;
    logic [NREG-1:0]   pending, pending_nxt;

    assign in_rst  = (rst == RstEnable);
    assign wb_req  = (wb_we == WriteEnable) && (wb_waddr != '0);
    assign head_v  = !fifo_empty;
    assign starved = (starve_cnt == CNT_MAX) && head_v;
    assign lu_ready = !in_rst && !fifo_full;
    // r0 results complete the handshake but never enter the buffer.
    assign lu_push = lu_valid && lu_ready && (lu_waddr != '0);

    rf_result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lu_push),
        .push_addr (lu_waddr),
        .push_data (lu_wdata),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = DATA_W'(ZeroWord);
        wb_stall = 1'b0;
        pop      = 1'b0;
        if (!in_rst) begin
            if (starved || (head_v && !wb_req)) begin
                rf_we    = 1'b1;
                rf_waddr = head_addr;
                rf_wdata = head_data;
                pop      = 1'b1;
                wb_stall = wb_req;
            end else if (wb_req) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end
        end
    end

    // Counts consecutive cycles the head lost to WB; any head write or empty FIFO restarts it.
    always_ff @(posedge clk) begin
        if (in_rst)
            starve_cnt <= '0;
        else if (pop || !head_v)
            starve_cnt <= '0;
        else if (wb_req && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        pending_nxt = pending;
        if (pop)
            pending_nxt[head_addr] = 1'b0;
        if (iss_valid && iss_waddr != '0)
            pending_nxt[iss_waddr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (in_rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign busy1  = !in_rst && pending[chk_raddr1];
    assign busy2  = !in_rst && pending[chk_raddr2];
    assign busy_w = !in_rst && pending[chk_waddr];
endmodule

// File: tb/tb_rf_wport_sched.sv
// Directed vector bench for rf_wport_sched: inputs change on the falling edge, outputs checked 1ns later.
module tb_rf_wport_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we, lu_valid, iss_valid;
    logic [4:0]  wb_waddr, lu_waddr, iss_waddr, chk_raddr1, chk_raddr2, chk_waddr;
    logic [31:0] wb_wdata, lu_wdata;
    logic        wb_stall, lu_ready, busy1, busy2, busy_w, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wwe;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          lv;
        logic [4:0]  la;
        logic [31:0] ld;
        bit          iv;
        logic [4:0]  ia;
        logic [4:0]  c1, c2, cw;
        bit          ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        bit          est, erdy, eb1, eb2, ebw;
    } vec_t;

    vec_t tbl[$];

    rf_wport_sched dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_stall(wb_stall),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
        .iss_valid(iss_valid), .iss_waddr(iss_waddr),
        .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2), .chk_waddr(chk_waddr),
        .busy1(busy1), .busy2(busy2), .busy_w(busy_w),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(bit wwe, logic [4:0] wa, logic [31:0] wd,
                               bit lv, logic [4:0] la, logic [31:0] ld,
                               bit iv, logic [4:0] ia,
                               logic [4:0] c1, logic [4:0] c2, logic [4:0] cw,
                               bit ewe, logic [4:0] ea, logic [31:0] ed,
                               bit est, bit erdy, bit eb1, bit eb2, bit ebw);
        vec_t r;
        r.wwe = wwe; r.wa = wa; r.wd = wd;
        r.lv = lv; r.la = la; r.ld = ld;
        r.iv = iv; r.ia = ia;
        r.c1 = c1; r.c2 = c2; r.cw = cw;
        r.ewe = ewe; r.ea = ea; r.ed = ed;
        r.est = est; r.erdy = erdy; r.eb1 = eb1; r.eb2 = eb2; r.ebw = ebw;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check just after, then advance one cycle.
    task automatic apply(input string tag, input vec_t t);
        wb_we = t.wwe; wb_waddr = t.wa; wb_wdata = t.wd;
        lu_valid = t.lv; lu_waddr = t.la; lu_wdata = t.ld;
        iss_valid = t.iv; iss_waddr = t.ia;
        chk_raddr1 = t.c1; chk_raddr2 = t.c2; chk_waddr = t.cw;
        #1;
        if (t.ewe)
            check({tag, " rf"}, {27'd0, rf_we, rf_waddr, rf_wdata}, {27'd0, 1'b1, t.ea, t.ed});
        else
            check({tag, " rf_we"}, {63'd0, rf_we}, 64'd0);
        check({tag, " flags(stall,rdy,b1,b2,bw)"},
              {59'd0, wb_stall, lu_ready, busy1, busy2, busy_w},
              {59'd0, t.est, t.erdy, t.eb1, t.eb2, t.ebw});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        // Reset is held with live requests on every input; all outputs must stay quiet.
        @(negedge clk);
        apply("reset", v(1,3,32'h33, 1,4,32'h44, 1,6, 6,6,6, 0,0,0, 0,0,0,0,0));
        apply("reset2", v(1,3,32'h33, 1,4,32'h44, 1,6, 6,6,6, 0,0,0, 0,0,0,0,0));
        rst = 1'b0;

        for (int i = 0; i < 32; i++)
            apply($sformatf("idle_r%0d", i), v(0,0,0, 0,0,0, 0,0, i[4:0],i[4:0],i[4:0], 0,0,0, 0,1,0,0,0));

        // LU only: issue r5, result pushed, written one cycle later.
        tbl.push_back(v(0,0,0, 0,0,0, 1,5, 5,0,0, 0,0,0, 0,1,0,0,0));
        tbl.push_back(v(0,0,0, 1,5,32'h1234, 0,0, 5,0,0, 0,0,0, 0,1,1,0,0));
        tbl.push_back(v(0,0,0, 0,0,0, 0,0, 5,0,0, 1,5,32'h1234, 0,1,1,0,0));
        tbl.push_back(v(0,0,0, 0,0,0, 0,0, 5,5,5, 0,0,0, 0,1,0,0,0));
        // Conflict: head r7 loses 4 times to WB r3, then wins with WB stalled.
        tbl.push_back(v(0,0,0, 0,0,0, 1,7, 0,0,7, 0,0,0, 0,1,0,0,0));
        tbl.push_back(v(1,3,32'h33, 1,7,32'hAA, 0,0, 0,0,7, 1,3,32'h33, 0,1,0,0,1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(1,3,32'h33, 0,0,0, 0,0, 0,0,7, 1,3,32'h33, 0,1,0,0,1));
        tbl.push_back(v(1,3,32'h33, 0,0,0, 0,0, 0,0,7, 1,7,32'hAA, 1,1,0,0,1));
        tbl.push_back(v(1,3,32'h33, 0,0,0, 0,0, 0,0,7, 1,3,32'h33, 0,1,0,0,0));
        // Full: two pushes under WB load, third held until the first pop.
        tbl.push_back(v(1,3,32'h44, 1,10,32'h100, 0,0, 0,0,0, 1,3,32'h44, 0,1,0,0,0));
        tbl.push_back(v(1,3,32'h44, 1,11,32'h101, 0,0, 0,0,0, 1,3,32'h44, 0,1,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(1,3,32'h44, 1,12,32'h102, 0,0, 0,0,0, 1,3,32'h44, 0,0,0,0,0));
        tbl.push_back(v(1,3,32'h44, 1,12,32'h102, 0,0, 0,0,0, 1,10,32'h100, 1,0,0,0,0));
        tbl.push_back(v(1,3,32'h44, 1,12,32'h102, 0,0, 0,0,0, 1,3,32'h44, 0,1,0,0,0));
        tbl.push_back(v(0,0,0, 0,0,0, 0,0, 0,0,0, 1,11,32'h101, 0,0,0,0,0));
        tbl.push_back(v(0,0,0, 0,0,0, 0,0, 0,0,0, 1,12,32'h102, 0,1,0,0,0));
        tbl.push_back(v(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1,0,0,0));
        // r0: WB to r0 does not block the head; iss/LU to r0 leave no trace.
        tbl.push_back(v(0,0,0, 1,13,32'h13, 0,0, 0,0,0, 0,0,0, 0,1,0,0,0));
        tbl.push_back(v(1,0,32'hDEAD, 0,0,0, 0,0, 0,0,0, 1,13,32'h13, 0,1,0,0,0));
        tbl.push_back(v(0,0,0, 1,0,32'h55, 1,0, 0,0,0, 0,0,0, 0,1,0,0,0));
        tbl.push_back(v(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1,0,0,0));
        // Set/clear collision on r9: reissue in the cycle its result is written.
        tbl.push_back(v(0,0,0, 0,0,0, 1,9, 0,0,9, 0,0,0, 0,1,0,0,0));
        tbl.push_back(v(0,0,0, 1,9,32'h99, 0,0, 9,0,9, 0,0,0, 0,1,1,0,1));
        tbl.push_back(v(0,0,0, 0,0,0, 1,9, 9,0,9, 1,9,32'h99, 0,1,1,0,1));
        tbl.push_back(v(0,0,0, 0,0,0, 0,0, 9,0,9, 0,0,0, 0,1,1,0,1));

        foreach (tbl[i])
            apply($sformatf("vec%0d", i), tbl[i]);

        // Mid-operation reset with two buffered results and pending r9/r20.
        apply("mr_push1", v(1,3,32'h33, 1,20,32'h1, 1,20, 20,0,9, 1,3,32'h33, 0,1,0,0,1));
        apply("mr_push2", v(1,3,32'h33, 1,21,32'h2, 0,0, 20,0,9, 1,3,32'h33, 0,1,1,0,1));
        apply("mr_full", v(1,3,32'h33, 0,0,0, 0,0, 20,0,9, 1,3,32'h33, 0,0,1,0,1));
        rst = 1'b1;
        apply("mr_rst", v(1,3,32'h33, 1,22,32'h3, 0,0, 20,21,9, 0,0,0, 0,0,0,0,0));
        rst = 1'b0;
        apply("mr_after", v(0,0,0, 0,0,0, 0,0, 20,21,9, 0,0,0, 0,1,0,0,0));
        apply("mr_after2", v(0,0,0, 0,0,0, 0,0, 20,21,9, 0,0,0, 0,1,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
